// File: rtl/riscv_pkg.sv
// Shared types for the rename-tag allocator / commit sequencer.
// Holds tag and data widths, the control state enum and the tag-entry layout.
package riscv_pkg;

  localparam int TAG_W = 6;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int DEPTH = 1 << TAG_W;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic             valid;
    logic             done;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  value;
  } entry_t;

endpackage

// File: rtl/tag_commit_ctrl_if.sv
// Decode/CDB/register-file signal bundle for tag_commit_ctrl.
// slave is the controller's view, master is the surrounding pipeline's view.
interface tag_commit_ctrl_if;

  logic                        alloc_req;
  logic                        alloc_has_rd;
  logic [riscv_pkg::REG_W-1:0] alloc_rd;
  logic                        alloc_gnt;
  logic [riscv_pkg::TAG_W-1:0] alloc_tag;
  logic                        full;
  logic                        empty;

  logic                        cdb_valid;
  logic [riscv_pkg::TAG_W-1:0] cdb_tag;
  logic [riscv_pkg::XLEN-1:0]  cdb_value;

  logic                        rf_issue_valid;
  logic [riscv_pkg::REG_W-1:0] rf_issue_rd;
  logic [riscv_pkg::TAG_W-1:0] rf_issue_tag;

  logic                        rf_wr_valid;
  logic [riscv_pkg::TAG_W-1:0] rf_wr_tag;
  logic [riscv_pkg::REG_W-1:0] rf_wr_rd;
  logic [riscv_pkg::XLEN-1:0]  rf_wr_value;

  logic                        flush_req;
  logic                        flush;

  modport master (
    output alloc_req, alloc_has_rd, alloc_rd, cdb_valid, cdb_tag, cdb_value, flush_req,
    input  alloc_gnt, alloc_tag, full, empty, rf_issue_valid, rf_issue_rd, rf_issue_tag,
    input  rf_wr_valid, rf_wr_tag, rf_wr_rd, rf_wr_value, flush
  );

  modport slave (
    input  alloc_req, alloc_has_rd, alloc_rd, cdb_valid, cdb_tag, cdb_value, flush_req,
    output alloc_gnt, alloc_tag, full, empty, rf_issue_valid, rf_issue_rd, rf_issue_tag,
    output rf_wr_valid, rf_wr_tag, rf_wr_rd, rf_wr_value, flush
  );

endinterface

// File: rtl/tag_ring_ptr.sv
// Head/tail/occupancy tracking for the circular tag ring.
// Pointers wrap naturally because the ring depth is a power of two.
module tag_ring_ptr #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [TAG_W-1:0] head,
  output logic [TAG_W-1:0] tail,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << TAG_W;
  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W + 1)'(DEPTH);

  logic [TAG_W-1:0] head_reg;
  logic [TAG_W-1:0] tail_reg;
  logic [TAG_W:0]   count_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (clr) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (inc) tail_reg <= tail_reg + 1'b1;
      if (dec) head_reg <= head_reg + 1'b1;
      if (inc && !dec)      count_reg <= count_reg + 1'b1;
      else if (dec && !inc) count_reg <= count_reg - 1'b1;
    end
  end

  assign head  = head_reg;
  assign tail  = tail_reg;
  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

endmodule

// File: rtl/tag_commit_ctrl.sv
// In-order rename-tag allocator and commit sequencer with flush sequencing.
// Define TAG_COMMIT_BYPASS_EN to let a CDB hit on the head entry commit at the same edge.
module tag_commit_ctrl
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  tag_commit_ctrl_if.slave  bus
);

  ctrl_state_t      state_reg;
  entry_t           ent_reg [DEPTH];
  logic             flush_reg;
  logic             wr_valid_reg;
  logic [TAG_W-1:0] wr_tag_reg;
  logic [REG_W-1:0] wr_rd_reg;
  logic [XLEN-1:0]  wr_value_reg;

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic             full;
  logic             empty;

  logic             run;
  logic             flush_start;
  logic             alloc_gnt;
  logic             cdb_hit;
  logic             bypass_hit;
  logic             commit;
  entry_t           head_ent;
  logic [XLEN-1:0]  commit_value;

  assign run         = (state_reg == RUN);
  assign flush_start = rdy & run & bus.flush_req;
  // full reflects the start-of-cycle count, so a same-cycle commit never frees a slot early
  assign alloc_gnt   = rdy & bus.alloc_req & ~full & run & ~bus.flush_req;
  assign head_ent    = ent_reg[head];
  assign cdb_hit     = rdy & run & ~bus.flush_req & bus.cdb_valid &
                       ent_reg[bus.cdb_tag].valid & ~ent_reg[bus.cdb_tag].done;

`ifdef TAG_COMMIT_BYPASS_EN
  assign bypass_hit   = cdb_hit & (bus.cdb_tag == head);
  assign commit_value = head_ent.done ? head_ent.value : bus.cdb_value;
`else
  assign bypass_hit   = 1'b0;
  assign commit_value = head_ent.value;
`endif

  assign commit = rdy & run & ~bus.flush_req & head_ent.valid & (head_ent.done | bypass_hit);

  tag_ring_ptr #(.TAG_W(TAG_W)) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush_start),
    .inc   (alloc_gnt),
    .dec   (commit),
    .head  (head),
    .tail  (tail),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent_reg[i] <= '0;
    end else if (flush_start) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg[i].valid <= 1'b0;
        ent_reg[i].done  <= 1'b0;
      end
    end else begin
      if (alloc_gnt) begin
        ent_reg[tail].valid <= 1'b1;
        ent_reg[tail].done  <= 1'b0;
        ent_reg[tail].rd    <= bus.alloc_has_rd ? bus.alloc_rd : '0;
      end
      if (cdb_hit) begin
        ent_reg[bus.cdb_tag].done  <= 1'b1;
        ent_reg[bus.cdb_tag].value <= bus.cdb_value;
      end
      if (commit) ent_reg[head].valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= RUN;
      flush_reg    <= 1'b0;
      wr_valid_reg <= 1'b0;
      wr_tag_reg   <= '0;
      wr_rd_reg    <= '0;
      wr_value_reg <= '0;
    end else if (rdy) begin
      case (state_reg)
        RUN: begin
          if (bus.flush_req) begin
            state_reg    <= FLUSH;
            flush_reg    <= 1'b1;
            wr_valid_reg <= 1'b0;
          end else begin
            flush_reg    <= 1'b0;
            wr_valid_reg <= commit & (head_ent.rd != '0);
            if (commit) begin
              wr_tag_reg   <= head;
              wr_rd_reg    <= head_ent.rd;
              wr_value_reg <= commit_value;
            end
          end
        end
        FLUSH: begin
          state_reg    <= RUN;
          flush_reg    <= 1'b0;
          wr_valid_reg <= 1'b0;
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign bus.alloc_gnt      = alloc_gnt;
  assign bus.alloc_tag      = tail;
  assign bus.full           = full;
  assign bus.empty          = empty;
  assign bus.rf_issue_valid = alloc_gnt & bus.alloc_has_rd & (bus.alloc_rd != '0);
  assign bus.rf_issue_rd    = bus.alloc_rd;
  assign bus.rf_issue_tag   = tail;
  assign bus.rf_wr_valid    = wr_valid_reg;
  assign bus.rf_wr_tag      = wr_tag_reg;
  assign bus.rf_wr_rd       = wr_rd_reg;
  assign bus.rf_wr_value    = wr_value_reg;
  assign bus.flush          = flush_reg;

endmodule
